serv_state_wide: RTL

Parametrised state/sequencing controller for the serial core family, with a configurable datapath width of W bits per cycle.
- Runs one pass over a 32-bit operand in 32/W cycles and sequences init/run stages for two-stage ops.
- Drives ibus/dbus cycle requests and RF read/write requests, and raises branch/misalign traps.
- Sits between decode, ALU/bufreg/CSR and the RF interface.
- New vs. the previous generation: width is generic, and a counter stall input lets the RF hold the datapath mid-pass.

---
 rtl/serv_state_wide.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/serv_state_wide.sv
// serv_state_wide: state and sequencing controller for the serial core family.
// It processes a W-bit chunk of a 32-bit operand per cycle.
//
// Parameters:
//   W              bits per cycle (1, 2, 4 or 8)
//   RESET_STRATEGY "NONE" leaves every state bit unreset except ibus_cyc
//   WITH_CSR       1 enables trap generation (o_ctrl_trap, misalign trap)
//   ALIGN          1 suppresses misaligned-jump traps
//
// Optional feature macro: SERV_STATE_WIDE_MDU_EN
//   When it is defined, MDU handshakes (o_mdu_valid, i_mdu_ready) take part.
//   When it is undefined, o_mdu_valid is 0 and i_mdu_op / i_mdu_ready are ignored.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rf_ready              starts a pass on the next cycle
//   i_cnt_stall             freezes the chunk counter mid-pass
//   i_* decode/status       decode controls, ALU compare, shifter/MDU/bus status
//   o_cnt_*                 pass state: enable, advance, chunk index, range flags
//   o_init                  current pass is the init stage of a two-stage op
//   o_ctrl_*, o_bufreg_en   datapath enables, jump and trap requests
//   o_ibus/dbus_cyc         bus cycle requests
//   o_rf_rreq/wreq/rd_en    register file requests
module serv_state_wide #(
    parameter int W              = 4,
    parameter     RESET_STRATEGY = "MINI",
    parameter int WITH_CSR       = 1,
    parameter int ALIGN          = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_new_irq,
    input  logic       i_alu_cmp,
    input  logic       i_ctrl_misalign,
    input  logic       i_mem_misalign,
    input  logic       i_sh_done,
    input  logic       i_sh_done_r,
    input  logic       i_bne_or_bge,
    input  logic       i_cond_branch,
    input  logic       i_branch_op,
    input  logic       i_two_stage_op,
    input  logic       i_shift_op,
    input  logic       i_sh_right,
    input  logic       i_slt_or_branch,
    input  logic       i_e_op,
    input  logic       i_rd_op,
    input  logic       i_dbus_en,
    input  logic       i_mdu_op,
    input  logic       i_mdu_ready,
    input  logic       i_ibus_ack,
    input  logic       i_dbus_ack,
    input  logic       i_rf_ready,
    input  logic       i_cnt_stall,
    output logic       o_init,
    output logic       o_cnt_en,
    output logic       o_cnt_adv,
    output logic [4:0] o_cnt_idx,
    output logic       o_cnt0to3,
    output logic       o_cnt12to31,
    output logic [4:0] o_cnt_sel,
    output logic       o_cnt_done,
    output logic [1:0] o_mem_bytecnt,
    output logic       o_bufreg_en,
    output logic       o_ctrl_pc_en,
    output logic       o_ctrl_jump,
    output logic       o_ctrl_trap,
    output logic       o_mdu_valid,
    output logic       o_dbus_cyc,
    output logic       o_ibus_cyc,
    output logic       o_rf_rreq,
    output logic       o_rf_wreq,
    output logic       o_rf_rd_en
);

    localparam int LW     = $clog2(W);
    localparam int CW     = 5 - LW;
    localparam bit RST_EN = (RESET_STRATEGY != "NONE");

    logic [CW-1:0] cnt;
    logic          init_done;
    logic          stage_two_req;
    logic          misalign_trap_sync;
    logic          ibus_cyc;
    logic          take_branch;
    logic          mdu_ready_term;

    // True when the chunk currently addressed by the counter covers bit b.
    function automatic logic chunk_has(input logic [CW-1:0] c, input int b);
        return c == CW'(b >> LW);
    endfunction

    assign o_cnt_adv     = o_cnt_en & !i_cnt_stall;
    assign o_cnt_idx     = 5'(cnt) << LW;
    assign o_cnt_done    = (&cnt) & o_cnt_adv;
    assign o_cnt0to3     = o_cnt_idx < 5'd4;
    assign o_cnt12to31   = o_cnt_idx >= 5'd12;
    assign o_cnt_sel     = {chunk_has(cnt, 7), chunk_has(cnt, 3), chunk_has(cnt, 2),
                            chunk_has(cnt, 1), chunk_has(cnt, 0)};
    assign o_mem_bytecnt = o_cnt_idx[4:3];

    assign take_branch  = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
    assign o_init       = i_two_stage_op & !i_new_irq & !init_done;
    assign o_ctrl_pc_en = o_cnt_adv & !o_init;
    assign o_ibus_cyc   = ibus_cyc & !i_rst;
    assign o_dbus_cyc   = !o_cnt_en & init_done & i_dbus_en & !i_mem_misalign;
    assign o_rf_rreq    = i_ibus_ack | (stage_two_req & misalign_trap_sync);
    assign o_rf_wreq    = !misalign_trap_sync & !o_cnt_en & init_done &
                          ((i_sh_done | !i_sh_right) | i_dbus_ack | mdu_ready_term |
                           i_slt_or_branch);
    assign o_rf_rd_en   = i_rd_op & !o_init;
    assign o_bufreg_en  = (o_cnt_adv & (o_init | ((o_ctrl_trap | i_branch_op) & i_two_stage_op))) |
                          (i_shift_op & !stage_two_req & (i_sh_right | i_sh_done_r) & init_done);

`ifdef SERV_STATE_WIDE_MDU_EN
    assign o_mdu_valid    = !o_cnt_en & init_done & i_mdu_op;
    assign mdu_ready_term = i_mdu_ready;
`else
    logic unused_mdu;
    assign unused_mdu     = i_mdu_op ^ i_mdu_ready;
    assign o_mdu_valid    = 1'b0;
    assign mdu_ready_term = 1'b0;
`endif

    // Pass sequencing. A new i_rf_ready wins over the end of the current pass.
    always_ff @(posedge i_clk) begin
        if (o_cnt_adv)
            cnt <= cnt + CW'(1);
        if (i_rf_ready)
            o_cnt_en <= 1'b1;
        else if (o_cnt_done)
            o_cnt_en <= 1'b0;
        if (o_cnt_done) begin
            init_done   <= o_init & !init_done;
            o_ctrl_jump <= o_init & take_branch;
        end
        stage_two_req <= o_cnt_done & o_init;
        if (RST_EN && i_rst) begin
            cnt           <= '0;
            o_cnt_en      <= 1'b0;
            init_done     <= 1'b0;
            o_ctrl_jump   <= 1'b0;
            stage_two_req <= 1'b0;
        end
    end

    // Fetch request: reset forces it high so the first fetch follows reset
    // release; afterwards it re-arms only when a non-init pass completes.
    always_ff @(posedge i_clk) begin
        if (i_ibus_ack | o_cnt_done | i_rst)
            ibus_cyc <= o_ctrl_pc_en | i_rst;
    end

    generate
        if (WITH_CSR != 0) begin : g_csr
            always_ff @(posedge i_clk) begin
                if (o_cnt_done)
                    misalign_trap_sync <= o_init &
                        ((take_branch & i_ctrl_misalign & (ALIGN == 0)) |
                         (i_dbus_en & i_mem_misalign));
                if (RST_EN && i_rst)
                    misalign_trap_sync <= 1'b0;
            end
            assign o_ctrl_trap = i_e_op | i_new_irq | misalign_trap_sync;
        end else begin : g_no_csr
            assign misalign_trap_sync = 1'b0;
            assign o_ctrl_trap        = 1'b0;
        end
    endgenerate

endmodule
